// File: rtl/ccff_loader.sv
// ccff_loader: serializes valid/ready stream words MSB-first onto an OpenFPGA
// configuration chain, stops after bit_count shifts and counts ones on ccff_tail.
module ccff_loader #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  bit_count,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              prog_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tail_ones
);

  localparam int WCNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [WCNT_W-1:0] wcnt;
  logic [CNT_W-1:0]  total_left;
  logic              start_acc;
  logic              shift_en;
  logic              hs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign start_acc = (state == IDLE) && start && !abort;
  assign shift_en  = (state == LOAD) && (wcnt != '0) && (total_left != '0);
  assign hs        = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = (bit_count == '0) ? FINISH : LOAD;
        LOAD:    if (total_left == '0) state_nxt = FINISH;
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Ready only when the current word is on its last bit (or empty) and more
  // bits are still needed than the current word can supply.
  always_comb begin
    s_ready = (state == LOAD) && (wcnt <= WCNT_W'(1)) && (total_left > CNT_W'(wcnt));
    busy    = (state == LOAD);
    done    = (state == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt       <= '0;
      total_left <= '0;
      prog_en    <= 1'b0;
      ccff_head  <= 1'b0;
      tail_ones  <= '0;
    end else if (abort) begin
      wcnt    <= '0;
      prog_en <= 1'b0;
    end else begin
      if (start_acc) begin
        total_left <= bit_count;
        wcnt       <= '0;
        tail_ones  <= '0;
      end else if (prog_en && ccff_tail) begin
        tail_ones <= sat_inc(tail_ones);
      end
      prog_en <= shift_en;
      if (shift_en) begin
        ccff_head  <= sreg[WORD_W-1];
        total_left <= total_left - CNT_W'(1);
      end
      // A fresh word overrides the decrement; its last-bit shift still happens above.
      if (hs)            wcnt <= WCNT_W'(WORD_W);
      else if (shift_en) wcnt <= wcnt - WCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!abort) begin
      if (hs)            sreg <= s_data;
      else if (shift_en) sreg <= {sreg[WORD_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: table of full loads plus abort/reset/start corner sequences.
module tb_ccff_loader;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 20;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  bit_count;
  logic              abort;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ccff_head;
  logic              prog_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  tail_ones;

  logic       tail_drv;
  logic       chain_mode;
  logic       chain_clr;
  logic [7:0] chain;

  int n_chk;
  int n_fail;

  ccff_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_count (bit_count),
    .abort     (abort),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .ccff_head (ccff_head),
    .prog_en   (prog_en),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done),
    .tail_ones (tail_ones)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 8-stage chain model: shifts ccff_head in on every prog_en edge.
  always @(posedge clk) begin
    if (chain_clr)    chain <= 8'h00;
    else if (prog_en) chain <= {chain[6:0], ccff_head};
  end
  assign ccff_tail = chain_mode ? chain[7] : tail_drv;

  typedef struct {
    logic [CNT_W-1:0] bc;
    logic [31:0]      w0;
    logic [31:0]      w1;
    int               stall;
    bit               poke;
    bit               chain;
    int               exp_prog;
    logic [63:0]      exp_bits;
    int               exp_hs;
    int               exp_bub;
    int               exp_tail;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_load(input vec_t v, input int row);
    int          prog;
    int          hs;
    int          dones;
    int          bubbles;
    int          pend;
    int          idx;
    int          stall_left;
    bit          first;
    bit          seen_done;
    logic [63:0] cap;
    logic [63:0] tail_at_done;
    logic        busy_at_done;
    string       tag;
    prog = 0; hs = 0; dones = 0; bubbles = 0; pend = 0; idx = 0;
    stall_left = v.stall; first = 1'b0; seen_done = 1'b0; cap = '0;
    tail_at_done = '0; busy_at_done = 1'b0;
    tag = $sformatf("row%0d", row);
    tail_drv = 1'b1; chain_mode = v.chain; chain_clr = 1'b1;
    @(posedge clk); #1;
    chain_clr = 1'b0;
    bit_count = v.bc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'(v.bc != 0));
    check({tag, " ready_after_start"}, 64'(s_ready), 64'(v.bc != 0));
    check({tag, " done_after_start"}, 64'(done), 64'(v.bc == 0));
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      if (prog_en) begin
        prog++;
        cap = {cap[62:0], ccff_head};
        if (first) bubbles += pend;
        pend = 0;
        first = 1'b1;
      end else if (first) begin
        pend++;
      end
      if (done) begin
        seen_done = 1'b1;
        dones++;
        tail_at_done = 64'(tail_ones);
        busy_at_done = busy;
      end
      if (v.poke && cyc == 5) begin
        start = 1'b1; bit_count = 20'd3;
      end else begin
        start = 1'b0;
      end
      if (idx == 1 && stall_left > 0 && s_ready) begin
        s_valid = 1'b0;
        stall_left--;
      end else begin
        s_valid = 1'b1;
        s_data  = (idx == 0) ? v.w0 : ((idx == 1) ? v.w1 : 32'hDEADBEEF);
      end
      if (s_valid && s_ready) begin
        hs++;
        idx++;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; start = 1'b0;
    if (!seen_done) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no done within cycle budget", tag);
    end
    check({tag, " done_single"}, 64'(done), 64'd0);
    check({tag, " prog_cycles"}, 64'(prog), 64'(v.exp_prog));
    check({tag, " head_bits"}, cap, v.exp_bits);
    check({tag, " handshakes"}, 64'(hs), 64'(v.exp_hs));
    check({tag, " bubbles"}, 64'(bubbles), 64'(v.exp_bub));
    check({tag, " done_pulses"}, 64'(dones), 64'd1);
    check({tag, " tail_ones"}, tail_at_done, 64'(v.exp_tail));
    check({tag, " busy_at_done"}, 64'(busy_at_done), 64'd0);
  endtask

  initial begin
    int pc;
    int dc;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b1; start = 1'b0; bit_count = '0; abort = 1'b0;
    s_data = '0; s_valid = 1'b0; tail_drv = 1'b0; chain_mode = 1'b0; chain_clr = 1'b1;

    tbl[0] = '{20'd40, 32'hA5A5A5A5, 32'hF0000000, 0, 1'b0, 1'b0, 40, 64'h000000A5A5A5A5F0, 2, 0, 40};
    tbl[1] = '{20'd40, 32'hA5A5A5A5, 32'hF0000000, 5, 1'b0, 1'b0, 40, 64'h000000A5A5A5A5F0, 2, 5, 40};
    tbl[2] = '{20'd32, 32'hFFFF0000, 32'h00000000, 0, 1'b0, 1'b1, 32, 64'h00000000FFFF0000, 1, 0, 16};
    tbl[3] = '{20'd40, 32'hA5A5A5A5, 32'hF0000000, 0, 1'b1, 1'b0, 40, 64'h000000A5A5A5A5F0, 2, 0, 40};
    tbl[4] = '{20'd0,  32'h12345678, 32'h9ABCDEF0, 0, 1'b0, 1'b0, 0,  64'h0,               0, 0, 0};
    tbl[5] = '{20'd33, 32'h80000001, 32'h80000000, 0, 1'b0, 1'b0, 33, 64'h0000000100000003, 2, 0, 33};
    tbl[6] = '{20'd64, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0, 1'b0, 64, 64'hFFFFFFFF00000001, 2, 0, 64};
    tbl[7] = '{20'd8,  32'h3C000000, 32'h00000000, 0, 1'b0, 1'b0, 8,  64'h000000000000003C, 1, 0, 8};

    #2 rst_n = 1'b0;
    #1;
    check("reset ccff_head", 64'(ccff_head), 64'd0);
    check("reset prog_en", 64'(prog_en), 64'd0);
    check("reset s_ready", 64'(s_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset tail_ones", 64'(tail_ones), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 8; r++) run_load(tbl[r], r);

    // Abort after 10 shifted bits.
    tail_drv = 1'b1; chain_mode = 1'b0;
    bit_count = 20'd40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    s_valid = 1'b0;
    pc = 0;
    for (int c = 0; c < 100 && pc < 10; c++) begin
      @(posedge clk); #1;
      if (prog_en) pc++;
    end
    check("abort prog_count_before", 64'(pc), 64'd10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort prog_en", 64'(prog_en), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort s_ready", 64'(s_ready), 64'd0);
    check("abort tail_ones", 64'(tail_ones), 64'd9);
    dc = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dc++;
      @(posedge clk); #1;
    end
    check("abort no_done", 64'(dc), 64'd0);
    check("abort tail_frozen", 64'(tail_ones), 64'd9);
    run_load(tbl[7], 107);

    // start and abort together in IDLE: abort wins.
    bit_count = 20'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort done", 64'(done), 64'd0);
    bit_count = 20'd8; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort busy", 64'(busy), 64'd0);
    check("start_abort s_ready", 64'(s_ready), 64'd0);

    // Asynchronous reset in the middle of a word.
    bit_count = 20'd40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 32'hF0F0F0F0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst ccff_head", 64'(ccff_head), 64'd0);
    check("midrst prog_en", 64'(prog_en), 64'd0);
    check("midrst s_ready", 64'(s_ready), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst tail_ones", 64'(tail_ones), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(tbl[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Bitstream loader for the OpenFPGA configuration chain. It accepts configuration words on a valid/ready stream and serializes them MSB-first onto `ccff_head`, one bit per `clk` and qualified by `prog_en`. It stops after exactly `bit_count` shifted bits, counts ones returning on `ccff_tail` for chain-integrity checks, and signals completion. It sits between the testbench/SoC bitstream source and the fabric's `ccff_head`/`ccff_tail` pins.

## Interface
- `WORD_W`, 32, stream word width; bits are consumed MSB first.
- `CNT_W`, 20, width of the bit counters; maximum load is 2^CNT_W-1 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a load; ignored while `busy`.
- `bit_count`  in  CNT_W  number of chain bits to shift; sampled on the `start` edge.
- `abort`  in  1  cancels a load in progress; has priority over all other activity.
- `s_data`  in  WORD_W  configuration word.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts `s_data` on this edge.
- `ccff_head`  out  1  serial bit to the chain head; registered.
- `prog_en`  out  1  shift qualifier; the chain shifts on every edge where `prog_en`=1; registered.
- `ccff_tail`  in  1  chain tail bit.
- `busy`  out  1  high from the edge after an accepted `start` until `done`/abort.
- `done`  out  1  one-cycle completion pulse.
- `tail_ones`  out  CNT_W  count of ones seen on `ccff_tail`, saturating.

## Operation
- **States:** IDLE, LOAD, FINISH.
  - IDLE → LOAD on `start` when `bit_count`≠0.
  - IDLE → FINISH on `start` when `bit_count`=0.
  - LOAD → FINISH when the remaining count `total_left` reaches 0.
  - FINISH → IDLE after one cycle; `done`=1 during FINISH.
- **Internal state:** shift register `sreg` (WORD_W bits), word-bit count `wcnt` (0..WORD_W), `total_left` (CNT_W bits).
- **On accepted `start`:** `total_left`←`bit_count`, `wcnt`←0, `tail_ones`←0.
- **Each LOAD edge with `wcnt`>0 and `total_left`>0:**
  - `ccff_head`←`sreg[WORD_W-1]`, `prog_en`←1.
  - `sreg` shifts left; `wcnt`−1; `total_left`−1.
- **Otherwise:** `prog_en`←0 and `ccff_head` holds its value (bubble).
- **`s_ready`** = LOAD && `wcnt`≤1 && `total_left`>`wcnt`. This is combinational from state, so it does not depend on `s_valid`.
- **Handshake (`s_valid`&&`s_ready`):** `sreg`←`s_data`, `wcnt`←WORD_W on that edge. This takes precedence over the decrement, so a word accepted while `wcnt`=1 still emits that last bit and gives gapless output.
- **Final word:** only the leading `total_left` bits are emitted; remaining bits are discarded. No further `s_ready` after the word carrying the last needed bit.
- **`tail_ones`:** increments on every edge where the registered `prog_en`=1 and `ccff_tail`=1, i.e. the tail value before that shift. Saturates at 2^CNT_W-1.
- **Abort:** on the next edge → IDLE; `prog_en`←0, `wcnt`←0, `s_ready` low. `done` is not pulsed and `tail_ones` holds.
- **`start` while `busy`:** ignored.
- **`start` and `abort` on the same edge in IDLE:** abort wins, so the block stays IDLE.
- **Output reset values:** `ccff_head`=0, `prog_en`=0, `s_ready`=0, `busy`=0, `done`=0, `tail_ones`=0. All internal counters are 0 and the state is IDLE.

## Timing
- `start` edge E0 → LOAD, with `busy`=1 and `s_ready`=1 in the cycle after E0.
- Word captured at edge Eh → first `prog_en`=1 cycle begins after edge Eh+1.
- Sustained throughput is 1 bit/clk when `s_valid` is held high: exactly WORD_W consecutive `prog_en` cycles per word, with no bubble between words.
- `prog_en` is high for exactly `bit_count` cycles in total, regardless of stalls.
- `done` is high in the cycle after the edge that clears the last `prog_en`. `busy` falls with `done`.
- `bit_count`=0: `done` one cycle after the `start` edge; no `s_ready`, no `prog_en`.

## Test plan
- **Gapless 40-bit load:** WORD_W=32, `bit_count`=40, words 0xA5A5A5A5 then 0xF0000000 with `s_valid` held → exactly 40 consecutive `prog_en` cycles; `ccff_head` = 1010…0101 then 1111_0000; `s_ready` accepted exactly twice; one `done`.
- **Source stall:** `s_valid` drops for 5 cycles after the first word → a 5-cycle `prog_en`=0 bubble with `ccff_head` held; total `prog_en` still 40; data order unchanged.
- **Tail count:** drive `ccff_tail` = `ccff_head` delayed 8 shifts (8-bit chain model preloaded with zeros), `bit_count`=32, word 0xFFFF0000 → `tail_ones`=16 at `done`.
- **Abort mid-load:** `abort` after 10 `prog_en` cycles → `prog_en`/`busy` low on the next edge, no `done`, `tail_ones` frozen. A following `start` with `bit_count`=8 then loads normally.
- **Zero and ignored starts:** `bit_count`=0 → `done` one cycle later with no handshake. A second `start` during a busy load leaves the bit count and `done` count unchanged.
- **Reset mid-load:** assert `rst_n`=0 asynchronously mid-word → all outputs at reset values immediately; the next load after release behaves as from power-up.
